screen_ram_arbiter: RTL
=======================

Name: screen_ram_arbiter

Overview:
- Responder side of the renderer's screen-read interface (`screen_read_en`, `screen_read_addr`, `screen_read_data`).
- Owns the single-port 2 KiB work/screen RAM shared by the 6502 core and the VGA renderer.
- When the renderer requests the bus, the block waits for a safe CPU boundary, stalls the CPU through RDY, serves video reads, then restores the CPU's pending access before releasing it.

Parameters:
- ADDR_WIDTH, 11, RAM word address width (2048 bytes).
- DATA_WIDTH, 8, RAM data width.
- HOLDOFF_MAX, 15, maximum cycles spent waiting for `cpu_sync` before a forced grant.

Ports:
- clk  in  1  system/pixel clock.
- reset  in  1  synchronous, active-high.
- vid_req  in  1  renderer bus request (`screen_read_en`); level, held for the whole line.
- vid_addr  in  ADDR_WIDTH  renderer read address.
- vid_data  out  DATA_WIDTH  read data; valid 1 cycle after `vid_addr` while granted.
- vid_gnt  out  1  high while video owns the RAM (state VIDEO).
- cpu_cs  in  1  CPU access targets this RAM.
- cpu_addr  in  ADDR_WIDTH  CPU address (low bits).
- cpu_we  in  1  CPU write strobe.
- cpu_wdata  in  DATA_WIDTH  CPU write data.
- cpu_sync  in  1  CPU opcode-fetch cycle (instruction boundary).
- cpu_rdata  out  DATA_WIDTH  CPU read data.
- cpu_rdy  out  1  6502 RDY; low stalls read cycles.
- ram_addr  out  ADDR_WIDTH  to `generic_ram`.
- ram_we  out  1  to `generic_ram`.
- ram_wdata  out  DATA_WIDTH  to `generic_ram`.
- ram_rdata  in  DATA_WIDTH  from `generic_ram`; synchronous read, 1-cycle latency.
- stall_cycles  out  16  stall statistics (see Optional Feature).

Behaviour:
- Reset values: state = CPU, `cpu_rdy` = 1, `vid_gnt` = 0, `ram_we` = 0, holdoff counter = 0, `cpu_rdata` hold register = 0, `stall_cycles` = 0.
- State CPU:
  - `ram_addr` = `cpu_addr`; `ram_we` = `cpu_cs & cpu_we`; `cpu_rdy` = 1.
  - `cpu_rdata` = `ram_rdata`; the hold register captures `ram_rdata` every cycle.
  - `vid_req` = 1 -> WAIT.
- State WAIT:
  - Same muxing as CPU; holdoff counter increments each cycle.
  - Transition to VIDEO when (`cpu_sync` & !`cpu_we`) or (counter == HOLDOFF_MAX & !`cpu_we`).
  - Never grant on a write cycle, because the 6502 ignores RDY on writes.
  - `vid_req` dropping in WAIT -> CPU; the counter clears.
- State VIDEO:
  - `cpu_rdy` = 0; `vid_gnt` = 1; `ram_addr` = `vid_addr`; `ram_we` = 0.
  - `cpu_addr` is latched on entry.
  - `cpu_rdata` = hold register, frozen.
  - `vid_data` = `ram_rdata`.
  - `vid_req` = 0 -> RESTORE.
- State RESTORE (1 cycle):
  - `cpu_rdy` = 0; `ram_addr` = latched `cpu_addr`; `ram_we` = 0.
  - Next cycle -> CPU, where `ram_rdata` already holds the CPU's stalled read data when `cpu_rdy` rises.
- Simultaneous events: `vid_req` reasserted during RESTORE is ignored until CPU, then the normal WAIT path applies. This gives the CPU at least one completed cycle per grant.
- Latency:
  - Grant is 1 to HOLDOFF_MAX+1 cycles after `vid_req` rises, plus any run of writes.
  - The renderer asserts its request 14 cycles before first pixel; budget accordingly.
- `vid_data` outside VIDEO is don't-care; the bench must not check it.
- Reset mid-VIDEO: return immediately to CPU with `cpu_rdy` = 1. No restore cycle is needed because the CPU is also reset.
- Addresses wrap modulo 2^ADDR_WIDTH.
- `cpu_cs` = 0 reads return `ram_rdata` unqualified; the CPU bus mux discards them.

Optional Feature:
- Macro: `SCREEN_ARB_STATS_EN`.
- Defined:
  - `stall_cycles` increments by 1 each cycle `cpu_rdy` = 0, saturating at 16'hFFFF.
  - Cleared by reset and on each `vid_req` rising edge when the previous value is consumed externally.
  - Rule: a clear occurs when `vid_req` rises while in CPU state and `stall_cycles` ≥ 16'hFFFF. Otherwise the counter accumulates per frame and software reads it via debug.
- Undefined: `stall_cycles` is tied to 16'h0000 and no counter logic is synthesized.

Decomposition:
- Shared package/header `screen_pkg.vh`:
  - State encodings CPU=2'd0, WAIT=2'd1, VIDEO=2'd2, RESTORE=2'd3.
  - SCREEN_BASE = 11'h200.
  - ADDR_WIDTH/DATA_WIDTH defaults.
- Optional sub-module `arb_holdoff_counter`: saturating counter with clear and terminal flag. The rest is a single module.

Test Plan:
- Reset mid-VIDEO (`vid_req` = 1, `cpu_rdy` = 0), then pulse reset -> next cycle state CPU, `cpu_rdy` = 1, `vid_gnt` = 0, `ram_we` = 0.
- CPU writes 8'h05 to 11'h200, `vid_req` held, `cpu_sync` at cycle 3 -> `vid_gnt` at cycle 4; `vid_addr` = 11'h200 yields `vid_data` = 8'h05 one cycle later.
- `vid_req` high, `cpu_sync` never asserted, no writes -> forced grant after exactly HOLDOFF_MAX = 15 wait cycles.
- Write cycle coincident with `cpu_sync`/holdoff expiry -> no grant that cycle; grant on the first following non-write cycle; write lands in RAM.
- CPU read of 11'h010 (8'hA7) stalled by a grant, `vid_req` drops -> RESTORE drives `ram_addr` = 11'h010; `cpu_rdy` rises with `cpu_rdata` = 8'hA7.
- With `SCREEN_ARB_STATS_EN` -> a 200-cycle grant gives `stall_cycles` = 201 (VIDEO + RESTORE). Without the macro -> `stall_cycles` reads 0.

Source files
------------

// File: rtl/screen_ram_arbiter_pkg.sv
// Shared definitions for the screen RAM arbiter: default geometry, screen
// base address and the ownership state encoding.
package screen_ram_arbiter_pkg;

   localparam int ADDR_WIDTH_DEF  = 11;   // 2 KiB work/screen RAM
   localparam int DATA_WIDTH_DEF  = 8;
   localparam int HOLDOFF_MAX_DEF = 15;

   // First byte of the character screen inside the work RAM.
   localparam logic [ADDR_WIDTH_DEF-1:0] SCREEN_BASE = 11'h200;

   typedef enum logic [1:0] {
      ST_CPU     = 2'd0,   // CPU owns the RAM
      ST_WAIT    = 2'd1,   // video pending, CPU still owns, waiting for a safe boundary
      ST_VIDEO   = 2'd2,   // video owns the RAM, CPU stalled via RDY
      ST_RESTORE = 2'd3    // re-issue the CPU's stalled read before releasing RDY
   } arb_state_t;

endpackage

// File: rtl/screen_ram_arbiter_holdoff.sv
// Saturating holdoff counter for the screen RAM arbiter.
// Ports:
//   clk, reset - clock, synchronous active-high reset
//   clr        - force count to zero (takes effect next cycle)
//   inc        - count one waiting cycle; sticks at HOLDOFF_MAX
//   term       - count has reached HOLDOFF_MAX
module screen_ram_arbiter_holdoff #(
   parameter int HOLDOFF_MAX = 15
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic inc,
   output logic term
);

   localparam int CW = (HOLDOFF_MAX < 1) ? 1 : $clog2(HOLDOFF_MAX + 1);
   localparam logic [CW-1:0] MAXV = CW'(HOLDOFF_MAX);

   logic [CW-1:0] cnt;

   // Saturation keeps term asserted while a run of CPU writes blocks the
   // forced grant, so the grant lands on the first non-write cycle.
   always_ff @(posedge clk) begin
      if (reset || clr)
         cnt <= '0;
      else if (inc && cnt != MAXV)
         cnt <= cnt + 1'b1;
   end

   assign term = (cnt == MAXV);

endmodule

// File: rtl/screen_ram_arbiter.sv
// Screen RAM arbiter: owns the single-port work/screen RAM shared by the 6502
// and the VGA renderer. A renderer request waits for an opcode fetch (or a
// holdoff timeout) on a non-write cycle, stalls the CPU through RDY, serves
// video reads, then re-issues the CPU's stalled read before releasing RDY.
//
// Ports:
//   clk, reset            - clock, synchronous active-high reset
//   vid_req/vid_addr      - renderer request level and read address
//   vid_data/vid_gnt      - renderer read data (1-cycle latency), grant
//   cpu_cs/addr/we/wdata  - CPU access to this RAM
//   cpu_sync              - CPU opcode-fetch cycle
//   cpu_rdata/cpu_rdy     - CPU read data, 6502 RDY
//   ram_addr/we/wdata     - to the synchronous RAM
//   ram_rdata             - from the RAM, 1-cycle read latency
//   stall_cycles          - CPU stall statistics
//
// Build option: define SCREEN_ARB_STATS_EN to count cycles with RDY low in
// stall_cycles (saturating); otherwise stall_cycles is tied to zero.
module screen_ram_arbiter
   import screen_ram_arbiter_pkg::*;
#(
   parameter int ADDR_WIDTH  = ADDR_WIDTH_DEF,
   parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
   parameter int HOLDOFF_MAX = HOLDOFF_MAX_DEF
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  vid_req,
   input  logic [ADDR_WIDTH-1:0] vid_addr,
   output logic [DATA_WIDTH-1:0] vid_data,
   output logic                  vid_gnt,
   input  logic                  cpu_cs,
   input  logic [ADDR_WIDTH-1:0] cpu_addr,
   input  logic                  cpu_we,
   input  logic [DATA_WIDTH-1:0] cpu_wdata,
   input  logic                  cpu_sync,
   output logic [DATA_WIDTH-1:0] cpu_rdata,
   output logic                  cpu_rdy,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic                  ram_we,
   output logic [DATA_WIDTH-1:0] ram_wdata,
   input  logic [DATA_WIDTH-1:0] ram_rdata,
   output logic [15:0]           stall_cycles
);

   arb_state_t            state, state_nxt;
   logic [DATA_WIDTH-1:0] hold_q;       // last read data the CPU saw
   logic [ADDR_WIDTH-1:0] cpu_addr_q;   // address of the access that gets stalled
   logic                  cpu_owns;
   logic                  hold_term;

   assign cpu_owns = (state == ST_CPU) || (state == ST_WAIT);

   // The counter is cleared whenever we are not waiting, so every WAIT entry
   // starts from zero; term rises after HOLDOFF_MAX completed wait cycles.
   screen_ram_arbiter_holdoff #(.HOLDOFF_MAX(HOLDOFF_MAX)) u_holdoff (
      .clk   (clk),
      .reset (reset),
      .clr   (state != ST_WAIT),
      .inc   (state == ST_WAIT),
      .term  (hold_term)
   );

   // Capturing the address every CPU-owned cycle means the value held during
   // VIDEO is the one from the grant cycle, i.e. the read the CPU repeats.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= ST_CPU;
         hold_q     <= '0;
         cpu_addr_q <= '0;
      end else begin
         state <= state_nxt;
         if (cpu_owns) begin
            hold_q     <= ram_rdata;
            cpu_addr_q <= cpu_addr;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      ram_addr  = cpu_addr;
      ram_we    = cpu_cs & cpu_we;
      cpu_rdy   = 1'b1;
      vid_gnt   = 1'b0;
      cpu_rdata = ram_rdata;
      unique case (state)
         ST_CPU: begin
            if (vid_req) state_nxt = ST_WAIT;
         end
         ST_WAIT: begin
            // The 6502 ignores RDY on writes, so a write cycle never grants.
            if (!vid_req)
               state_nxt = ST_CPU;
            else if (!cpu_we && (cpu_sync || hold_term))
               state_nxt = ST_VIDEO;
         end
         ST_VIDEO: begin
            cpu_rdy   = 1'b0;
            vid_gnt   = 1'b1;
            ram_addr  = vid_addr;
            ram_we    = 1'b0;
            cpu_rdata = hold_q;
            if (!vid_req) state_nxt = ST_RESTORE;
         end
         ST_RESTORE: begin
            // Re-read the stalled address so its data is on ram_rdata the
            // cycle RDY rises; vid_req is ignored here.
            cpu_rdy   = 1'b0;
            ram_addr  = cpu_addr_q;
            ram_we    = 1'b0;
            cpu_rdata = hold_q;
            state_nxt = ST_CPU;
         end
         default: state_nxt = ST_CPU;
      endcase
   end

   assign ram_wdata = cpu_wdata;
   assign vid_data  = ram_rdata;

`ifdef SCREEN_ARB_STATS_EN
   logic [15:0] stall_q;
   logic        vid_req_q;

   // A saturated count is treated as consumed: the next request edge seen
   // while the CPU owns the RAM restarts it from zero.
   always_ff @(posedge clk) begin
      if (reset) begin
         stall_q   <= '0;
         vid_req_q <= 1'b0;
      end else begin
         vid_req_q <= vid_req;
         if (state == ST_CPU && vid_req && !vid_req_q && stall_q == 16'hFFFF)
            stall_q <= '0;
         else if (!cpu_rdy && stall_q != 16'hFFFF)
            stall_q <= stall_q + 16'd1;
      end
   end

   assign stall_cycles = stall_q;
`else
   assign stall_cycles = 16'h0000;
`endif

endmodule
